// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH programmable 50%-duty clock dividers with phase sync and glitch-free reprogramming
module multi_clock_divider #(
  parameter int NUM_CH = 4,
  parameter int CNT_WIDTH = 24,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_HALF = CNT_WIDTH'(12499999),
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic                 sync,
  input  logic                 cfg_valid,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [CNT_WIDTH-1:0] cfg_half,
  output logic                 cfg_ready,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick
);
  logic [NUM_CH-1:0] pend_v;
  // A channel takes a new value only when in range and no earlier write is still waiting to land
  always_comb begin
    cfg_ready = 1'b0;
    for (int k = 0; k < NUM_CH; k++) if (cfg_ch == CH_W'(k)) cfg_ready = ~pend_v[k];
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, half_q, half_d, pend_val_q, pend_val_d;
    logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, clr, toggle, acc, apply;
    // Disable beats sync beats toggle beats increment; a pending value lands only at a phase boundary
    always_comb begin
      clr = ~ch_en[i] | sync;
      toggle = cnt_q >= half_q;
      acc = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
      apply = pend_q & (clr | toggle);
      cnt_d = (clr | toggle) ? '0 : cnt_q + 1'b1;
      clk_d = ~clr & (clk_q ^ toggle);
      tick_d = ~clr & toggle;
      half_d = apply ? pend_val_q : half_q;
      pend_d = acc | (pend_q & ~apply);
      pend_val_d = acc ? cfg_half : pend_val_q;
    end
    // Channel state register; reset restores the default rate and drops any pending write
    always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        half_q <= DEFAULT_HALF;
        pend_val_q <= DEFAULT_HALF;
        pend_q <= 1'b0;
        clk_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        half_q <= half_d;
        pend_val_q <= pend_val_d;
        pend_q <= pend_d;
        clk_q <= clk_d;
        tick_q <= tick_d;
      end
    end
    assign clk_out[i] = clk_q;
    assign tick[i] = tick_q;
    assign pend_v[i] = pend_q;
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: random and directed checks against a deadline-based channel model
module tb_multi_clock_divider;
  localparam int NUM_CH = 3;
  localparam int CNT_WIDTH = 4;
  localparam int CH_W = 2;
  localparam logic [CNT_WIDTH-1:0] DEF = 4'd3;
  logic clk_50m = 0, rst_n = 0, sync = 0, cfg_valid = 0, cfg_ready;
  logic [NUM_CH-1:0] ch_en = '1, clk_out, tick;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [CNT_WIDTH-1:0] cfg_half = '0;
  int checks = 0, errors = 0, t = 0;
  int m_half[4], m_pval[4], m_due[4];
  bit m_pend[4], m_lvl[4], m_tick[4];

  multi_clock_divider #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .DEFAULT_HALF(DEF)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .ch_en(ch_en), .sync(sync), .cfg_valid(cfg_valid),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_ready(cfg_ready), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, t);
    end
  endtask

  // Model: each channel keeps the absolute edge number of its next toggle
  task automatic mreset();
    t = 0;
    for (int c = 0; c < 4; c++) begin
      m_half[c] = DEF; m_pval[c] = DEF; m_pend[c] = 0;
      m_lvl[c] = 0; m_tick[c] = 0; m_due[c] = DEF + 1;
    end
  endtask

  task automatic step(input logic [NUM_CH-1:0] en, input logic s, input logic v,
                      input logic [CH_W-1:0] ch, input logic [CNT_WIDTH-1:0] h);
    logic rdy;
    logic [NUM_CH-1:0] el, et;
    @(negedge clk_50m);
    ch_en = en; sync = s; cfg_valid = v; cfg_ch = ch; cfg_half = h;
    #1;
    rdy = (int'(ch) < NUM_CH) && !m_pend[ch];
    check("cfg_ready", cfg_ready, rdy);
    @(posedge clk_50m);
    t++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!en[c] || s || t == m_due[c]) begin
        if (m_pend[c]) begin m_half[c] = m_pval[c]; m_pend[c] = 0; end
        m_tick[c] = en[c] && !s;
        m_lvl[c] = m_tick[c] ? !m_lvl[c] : 1'b0;
        m_due[c] = t + m_half[c] + 1;
      end else m_tick[c] = 0;
    end
    if (v && rdy) begin m_pend[ch] = 1; m_pval[ch] = int'(h); end
    for (int c = 0; c < NUM_CH; c++) begin el[c] = m_lvl[c]; et[c] = m_tick[c]; end
    #1;
    check("clk_out", clk_out, el);
    check("tick", tick, et);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('1, 0, 0, 0, 0);
  endtask

  initial begin
    logic [NUM_CH-1:0] en;
    mreset();
    repeat (2) @(negedge clk_50m);
    check("rst clk_out", clk_out, 0);
    check("rst tick", tick, 0);
    cfg_ch = 2; #1 check("rst ready ch2", cfg_ready, 1);
    cfg_ch = 3; #1 check("rst ready oor", cfg_ready, 0);
    cfg_ch = 0;
    @(posedge clk_50m); #1 rst_n = 1;
    // defaults: rise at edge 4, period 8, tick at every 4th edge
    for (int e = 1; e <= 12; e++) begin
      idle(1);
      check("dflt clk", clk_out, ((e / 4) % 2) ? 3'b111 : 3'b000);
      check("dflt tick", tick, (e % 4 == 0) ? 3'b111 : 3'b000);
    end
    // mid-period reprogram of ch0 to half=1
    idle(1);
    step('1, 0, 1, 0, 1);
    #1 check("stall ready", cfg_ready, 0);
    step('1, 0, 1, 0, 2);
    idle(1);
    check("reprog keep 16", {clk_out[0], tick[0]}, 2'b01);
    idle(1);
    check("reprog 17", clk_out[0], 0);
    idle(1);
    check("reprog 18", {clk_out[0], tick[0]}, 2'b11);
    idle(2);
    check("reprog 20", {clk_out[0], tick[0]}, 2'b01);
    // reset mid-operation with a pending write on ch1 while clk_out[1] is high
    step('1, 0, 1, 1, 0);
    check("pre-reset clk1", clk_out[1], 1);
    @(negedge clk_50m); rst_n = 0;
    #1 check("async clr clk", clk_out, 0);
    check("async clr tick", tick, 0);
    mreset();
    @(posedge clk_50m); #1 rst_n = 1;
    idle(4);
    check("post-reset rise", clk_out, 3'b111);
    idle(1);
    check("pending lost", clk_out[1], 1);
    // sync with a pending write on ch1 applied at the sync
    idle(2);
    step('1, 0, 1, 1, 5);
    step('1, 1, 0, 0, 0);
    check("sync clear", clk_out, 0);
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      check("sync ch0", clk_out[0], k >= 4);
      check("sync ch1", clk_out[1], k >= 6);
    end
    // disable ch1 while high, program while disabled, re-enable
    step(3'b101, 0, 0, 0, 0);
    check("dis clr", {clk_out[1], tick[1]}, 2'b00);
    step(3'b101, 0, 1, 1, 1);
    step(3'b101, 0, 0, 0, 0);
    step('1, 0, 0, 0, 0);
    check("reen 1", clk_out[1], 0);
    step('1, 0, 0, 0, 0);
    check("reen 2", clk_out[1], 1);
    // boundary: half=0 on ch2, max half on ch0
    step('1, 0, 1, 2, 0);
    idle(5);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      check("half0 tick", tick[2], 1);
    end
    step('1, 0, 1, 0, 4'hf);
    idle(80);
    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < NUM_CH; c++) en[c] = ($urandom_range(0, 15) != 0);
      step(en, $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0, CH_W'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? CNT_WIDTH'($urandom_range(0, 15)) : CNT_WIDTH'($urandom_range(0, 4)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

- Parametrised successor to the fixed 50 MHz→2 Hz divider.
- Generates NUM_CH independent divided clocks from one system clock. Each channel has:
  - a runtime-programmable half-period,
  - an enable,
  - a one-cycle toggle tick.
- A global sync input phase-aligns all channels.
- Sits between the board clock and slow consumers (LED blinkers, scan timers, debouncers).
- Configured through a valid/ready write port, so reprogramming never produces a truncated half-period.

## Interface
- NUM_CH, 4, number of output channels (1..16)
- CNT_WIDTH, 24, counter and half-period register width
- DEFAULT_HALF, 12499999, reset half-period value for every channel (2 Hz at 50 MHz)
- CH_W, max(1,$clog2(NUM_CH)), width of cfg_ch
- clk_50m  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- ch_en  in  NUM_CH  per-channel enable, level
- sync  in  1  one-cycle pulse: restart all enabled channels in phase
- cfg_valid  in  1  config write request
- cfg_ch  in  CH_W  target channel index
- cfg_half  in  CNT_WIDTH  new half-period value; half-period = cfg_half+1 cycles
- cfg_ready  out  1  write accepted when cfg_valid & cfg_ready
- clk_out  out  NUM_CH  divided clocks, registered
- tick  out  NUM_CH  one-cycle pulse coincident with each clk_out toggle, registered

## Operation
- **Per-channel state:** cnt[CNT_WIDTH], half[CNT_WIDTH], pend_val[CNT_WIDTH], pend flag, clk_out bit, tick bit.
- **Count, enabled, no sync:**
  - If cnt >= half: cnt<=0, clk_out<=~clk_out, tick<=1.
  - Else: cnt<=cnt+1, tick<=0.
  - Output period = 2*(half+1) cycles; duty exactly 50%. half=0 gives divide-by-2.
- **Disabled (ch_en[i]=0):** cnt<=0, clk_out<=0, tick<=0, held there. Re-enable starts a fresh low half-period.
- **sync=1:** every enabled channel gets cnt<=0, clk_out<=0, tick<=0. Disabled channels are unaffected; they are already cleared.
- **Priority per channel:** disable > sync > toggle > increment.
- **Config handshake:**
  - cfg_ready = (cfg_ch < NUM_CH) & ~pend[cfg_ch]. Combinational from cfg_ch and registered pend.
  - On acceptance: pend_val<=cfg_half, pend<=1 for that channel.
  - Out-of-range cfg_ch: never ready, never written.
- **Pending apply:** half<=pend_val, pend<=0 at the first of the following events, in a cycle after the acceptance cycle:
  - the channel's toggle event,
  - a sync pulse,
  - any cycle with the channel disabled.
- The current half-period always completes with the old value, so no runt or stretched phase arises from reprogramming.
- **Widths:** counter wraps only via the compare. cnt+1 never overflows because cnt <= half <= 2^CNT_WIDTH-1.

## Timing
- **Reset values (asynchronous, immediate):**
  - cnt=0, clk_out=0, tick=0, pend=0
  - half=DEFAULT_HALF, pend_val=DEFAULT_HALF
  - cfg_ready follows cfg_ch validity
- **First toggle:** with ch_en high from reset release, the first clk_out rise and tick occur on the (half+1)th rising edge after rst_n deasserts.
- **Toggle pulse:** tick is high for exactly one cycle, in the same cycle clk_out changes.
- **Sync:** sync asserted in cycle k gives clk_out=0, cnt=0 visible at cycle k+1; the next rise is at cycle k+1+half+1.
- **Config latency:** acceptance in cycle k makes cfg_ready low for that channel from k+1 until the cycle after the apply event.
- **Accept coinciding with a toggle:** the new value is not used for that toggle; it applies at the following one.
- **Reset mid-operation:**
  - Outputs clear at once and pending writes are discarded.
  - half reverts to DEFAULT_HALF.

## Test plan
- **Reset defaults:** DEFAULT_HALF=3, NUM_CH=2, both enabled after reset -> clk_out rises at edge 4, period 8, tick high one cycle at edges 4, 8, 12; cfg_ready=1 for ch 0, 1 and 0 for cfg_ch=2 (if CH_W allows).
- **Mid-period reprogram:** ch0 running half=3, write cfg_half=1 at cnt=1 -> current half-period stays 4 cycles, then period 4; cfg_ready for ch0 low until apply, and a second write is stalled.
- **Sync alignment:** ch0 half=3, ch1 half=5 at arbitrary phases, pulse sync -> both clk_out=0 next cycle; first rises 4 and 6 cycles later; a pending write on ch1 applies at the sync.
- **Disable/enable:** drop ch_en[1] while clk_out[1]=1 -> clk_out[1]=0, tick[1]=0 next cycle; a write while disabled applies next cycle; re-enable gives the first rise after new half+1 cycles.
- **Boundary values:** cfg_half=0 -> clk_out toggles every cycle, tick continuously high; cfg_half=2^CNT_WIDTH-1 (CNT_WIDTH=4) -> period 32, no wrap glitch.
- **Reset mid-operation:** assert rst_n=0 with a pending write and clk_out=1 -> immediate clear; after release the period is from DEFAULT_HALF and the pending value is lost.
